// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM with a memory wait-state timeout.
// Optional feature macro MC_CTRL_ILLEGAL_EN: trap unsupported instructions through EXC.
module mc_ctrl #(
  parameter int unsigned ALUOP_W  = 5,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               extop,
  output logic               ALUSrc,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         s,
  output logic [ALUOP_W-1:0] aluop,
  output logic [2:0]         state,
  output logic               bus_err,
  output logic               illegal
);

  localparam int unsigned WCNT_W = $clog2(MAX_WAIT);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(6);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_EXC = 3'd5, S_ERR = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_R, C_I, C_LW, C_SW, C_BEQ, C_J, C_JR, C_JAL
  } cls_t;

  state_t             state_q, state_d;
  cls_t               cls_q, d_cls;
  logic               extop_q, d_extop, alusrc_q, d_alusrc;
  logic [1:0]         regdst_q, d_regdst, memtoreg_q, d_memtoreg, s_q, d_s;
  logic [ALUOP_W-1:0] aluop_q, d_aluop;
  logic [WCNT_W-1:0]  wait_cnt;
  logic               cnt_inc, timeout;
  logic               pcw_c, pcwc_c, irw_c, mr_c, mw_c, rw_c;

  always_comb begin
    d_cls      = C_ILL;
    d_extop    = 1'b0;
    d_alusrc   = 1'b0;
    d_regdst   = 2'b00;
    d_memtoreg = 2'b00;
    d_s        = 2'b00;
    d_aluop    = '0;
    case (op)
      6'h00: begin
        d_regdst   = 2'b01;
        d_memtoreg = 2'b01;
        case (funct)
          6'h20: begin d_cls = C_R; d_aluop = ALU_ADD;  end
          6'h21: begin d_cls = C_R; d_aluop = ALU_ADDU; end
          6'h23: begin d_cls = C_R; d_aluop = ALU_SUB;  end
          6'h24: begin d_cls = C_R; d_aluop = ALU_AND;  end
          6'h25: begin d_cls = C_R; d_aluop = ALU_OR;   end
          6'h2a: begin d_cls = C_R; d_aluop = ALU_SLT;  end
          6'h08: begin
            d_cls = C_JR; d_s = 2'b11; d_regdst = 2'b00; d_memtoreg = 2'b00;
          end
          default: begin d_regdst = 2'b00; d_memtoreg = 2'b00; end
        endcase
      end
      6'h08: begin d_cls = C_I; d_extop = 1'b1; d_alusrc = 1'b1; d_memtoreg = 2'b01; d_aluop = ALU_ADD;  end
      6'h09: begin d_cls = C_I; d_extop = 1'b1; d_alusrc = 1'b1; d_memtoreg = 2'b01; d_aluop = ALU_ADDU; end
      6'h0c: begin d_cls = C_I; d_alusrc = 1'b1; d_memtoreg = 2'b01; d_aluop = ALU_AND; end
      6'h0d: begin d_cls = C_I; d_alusrc = 1'b1; d_memtoreg = 2'b01; d_aluop = ALU_OR;  end
      6'h0f: begin d_cls = C_I; d_alusrc = 1'b1; d_memtoreg = 2'b01; d_aluop = ALU_LUI; end
      6'h23: begin d_cls = C_LW; d_extop = 1'b1; d_alusrc = 1'b1; d_memtoreg = 2'b10; d_aluop = ALU_ADD; end
      6'h2b: begin d_cls = C_SW; d_extop = 1'b1; d_alusrc = 1'b1; d_aluop = ALU_ADD; end
      6'h04: begin d_cls = C_BEQ; d_extop = 1'b1; d_s = 2'b01; d_aluop = ALU_SUB; end
      6'h02: begin d_cls = C_J; d_s = 2'b10; end
      6'h03: begin d_cls = C_JAL; d_s = 2'b10; d_regdst = 2'b10; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IF;
      wait_cnt   <= '0;
      cls_q      <= C_ILL;
      extop_q    <= 1'b0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 2'b00;
      memtoreg_q <= 2'b00;
      s_q        <= 2'b00;
      aluop_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wait_cnt <= '0;
      else if (cnt_inc)       wait_cnt <= wait_cnt + 1'b1;
      if (state_q == S_ID) begin
        cls_q      <= d_cls;
        extop_q    <= d_extop;
        alusrc_q   <= d_alusrc;
        regdst_q   <= d_regdst;
        memtoreg_q <= d_memtoreg;
        s_q        <= d_s;
        aluop_q    <= d_aluop;
      end
    end
  end

  assign timeout = (wait_cnt == WCNT_W'(MAX_WAIT - 1));

  // s is steered combinationally in IF/ID so jumps can load the PC before the word registers
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    pcw_c   = 1'b0;
    pcwc_c  = 1'b0;
    irw_c   = 1'b0;
    mr_c    = 1'b0;
    mw_c    = 1'b0;
    rw_c    = 1'b0;
    i_or_d  = 1'b0;
    s       = s_q;
    case (state_q)
      S_IF: begin
        mr_c = 1'b1;
        s    = 2'b00;
        if (mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_ID;
        end else if (timeout) state_d = S_ERR;
        else                  cnt_inc = 1'b1;
      end
      S_ID: begin
        s = d_s;
        case (d_cls)
          C_J, C_JR: begin pcw_c = 1'b1; state_d = S_IF; end
          C_JAL:     state_d = S_WB;
          C_ILL: begin
`ifdef MC_CTRL_ILLEGAL_EN
            state_d = S_EXC;
`else
            state_d = S_IF;
`endif
          end
          default:   state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (cls_q)
          C_BEQ:      begin pcwc_c = 1'b1; state_d = S_IF; end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        mr_c   = (cls_q == C_LW);
        mw_c   = (cls_q == C_SW);
        if (mem_ready)    state_d = (cls_q == C_LW) ? S_WB : S_IF;
        else if (timeout) state_d = S_ERR;
        else              cnt_inc = 1'b1;
      end
      S_WB: begin
        rw_c    = 1'b1;
        pcw_c   = (cls_q == C_JAL);
        state_d = S_IF;
      end
      S_EXC:   state_d = S_IF;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IF;
    endcase
  end

  // Strobes are gated by rst so an in-flight access drops before the register reset settles
  assign pc_write      = pcw_c  & ~rst;
  assign pc_write_cond = pcwc_c & ~rst;
  assign ir_write      = irw_c  & ~rst;
  assign mem_read      = mr_c   & ~rst;
  assign mem_write     = mw_c   & ~rst;
  assign reg_write     = rw_c   & ~rst;

  assign extop    = extop_q;
  assign ALUSrc   = alusrc_q;
  assign RegDst   = regdst_q;
  assign MemtoReg = memtoreg_q;
  assign aluop    = aluop_q;
  assign state    = state_q;
  assign bus_err  = (state_q == S_ERR);

`ifdef MC_CTRL_ILLEGAL_EN
  assign illegal = (state_q == S_EXC);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: decode table, random instruction/wait mix, reset and timeout corners.
module tb_mc_ctrl;
  localparam int unsigned MW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic       extop, ALUSrc;
  logic [1:0] RegDst, MemtoReg, s;
  logic [4:0] aluop;
  logic [2:0] state;
  logic       bus_err, illegal;

  mc_ctrl #(.ALUOP_W(5), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .extop(extop), .ALUSrc(ALUSrc), .RegDst(RegDst), .MemtoReg(MemtoReg), .s(s),
    .aluop(aluop), .state(state), .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_JR, K_JAL, K_BAD} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    kind_e      kind;
    logic       extop;
    logic       alusrc;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [4:0] aluop;
    int         cycles;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       rdy, rdy_any;
    logic       mr, mw, iod, irw, pcw, pcwc, rw, ill, berr;
    logic [1:0] s;
    logic       chk_s, chk_cw;
    logic       extop, alusrc;
    logic [1:0] regdst, memtoreg;
    logic [4:0] aluop;
  } exp_t;

`ifdef MC_CTRL_ILLEGAL_EN
  localparam int BAD_CYC = 3;
`else
  localparam int BAD_CYC = 2;
`endif

  vec_t tbl[19];
  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mkv(logic [5:0] o, logic [5:0] f, kind_e k, logic ex, logic src,
                               logic [1:0] rd, logic [1:0] mtr, logic [4:0] alu, int cyc);
    vec_t v;
    v.op = o; v.funct = f; v.kind = k; v.extop = ex; v.alusrc = src;
    v.regdst = rd; v.memtoreg = mtr; v.aluop = alu; v.cycles = cyc;
    return v;
  endfunction

  function automatic exp_t mk(logic [2:0] st);
    exp_t e;
    e = '{default: '0};
    e.st = st;
    e.rdy_any = 1'b1;
    return e;
  endfunction

  function automatic exp_t cw(exp_t ein, vec_t v);
    exp_t e;
    e = ein;
    e.chk_cw = 1'b1;
    e.extop = v.extop; e.alusrc = v.alusrc; e.regdst = v.regdst;
    e.memtoreg = v.memtoreg; e.aluop = v.aluop;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected per-cycle trace of one instruction, from the state-sequence rules
  task automatic build(input vec_t v, input int w_if, input int w_mem);
    exp_t e;
    for (int i = 0; i < w_if; i++) begin
      e = mk(3'd0); e.rdy_any = 1'b0; e.rdy = 1'b0; e.mr = 1'b1; q.push_back(e);
    end
    e = mk(3'd0); e.rdy_any = 1'b0; e.rdy = 1'b1; e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    e.chk_s = 1'b1; e.s = 2'b00; q.push_back(e);
    e = mk(3'd1);
    case (v.kind)
      K_J:  begin e.pcw = 1'b1; e.chk_s = 1'b1; e.s = 2'b10; q.push_back(e); return; end
      K_JR: begin e.pcw = 1'b1; e.chk_s = 1'b1; e.s = 2'b11; q.push_back(e); return; end
      K_BAD: begin
        q.push_back(e);
`ifdef MC_CTRL_ILLEGAL_EN
        e = mk(3'd5); e.ill = 1'b1; q.push_back(e);
`endif
        return;
      end
      K_JAL: begin
        q.push_back(e);
        e = cw(mk(3'd4), v); e.rw = 1'b1; e.pcw = 1'b1; e.chk_s = 1'b1; e.s = 2'b10;
        q.push_back(e);
        return;
      end
      default: q.push_back(e);
    endcase
    e = cw(mk(3'd2), v);
    if (v.kind == K_BEQ) begin
      e.pcwc = 1'b1; e.chk_s = 1'b1; e.s = 2'b01; q.push_back(e); return;
    end
    q.push_back(e);
    if (v.kind == K_LW || v.kind == K_SW) begin
      for (int i = 0; i <= w_mem; i++) begin
        e = cw(mk(3'd3), v); e.rdy_any = 1'b0; e.rdy = (i == w_mem); e.iod = 1'b1;
        e.mr = (v.kind == K_LW); e.mw = (v.kind == K_SW); q.push_back(e);
      end
      if (v.kind == K_SW) return;
    end
    e = cw(mk(3'd4), v); e.rw = 1'b1; q.push_back(e);
  endtask

  // Entered and left at 1 time unit after a rising edge; one record per clock cycle
  task automatic run_queue(output int obs_len);
    exp_t        e;
    logic [24:0] a, x;
    int          k;
    k = 0;
    obs_len = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.rdy_any ? 1'($urandom_range(0, 1)) : e.rdy;
      #2;
      k++;
      if (state != 3'd0) obs_len = k;
      a = {state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, reg_write,
           illegal, bus_err, e.chk_s ? s : 2'b00,
           e.chk_cw ? {extop, ALUSrc, RegDst, MemtoReg, aluop} : 11'd0};
      x = {e.st, e.mr, e.mw, e.iod, e.irw, e.pcw, e.pcwc, e.rw, e.ill, e.berr,
           e.chk_s ? e.s : 2'b00,
           e.chk_cw ? {e.extop, e.alusrc, e.regdst, e.memtoreg, e.aluop} : 11'd0};
      check($sformatf("cycle%0d_st%0d", k, e.st), 32'(a), 32'(x));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int   obs, wi, wm;
    vec_t v;
    exp_t e;

    tbl[0]  = mkv(6'h00, 6'h20, K_R,   1'b0, 1'b0, 2'b01, 2'b01, 5'd0, 4);
    tbl[1]  = mkv(6'h00, 6'h21, K_R,   1'b0, 1'b0, 2'b01, 2'b01, 5'd1, 4);
    tbl[2]  = mkv(6'h00, 6'h23, K_R,   1'b0, 1'b0, 2'b01, 2'b01, 5'd2, 4);
    tbl[3]  = mkv(6'h00, 6'h24, K_R,   1'b0, 1'b0, 2'b01, 2'b01, 5'd3, 4);
    tbl[4]  = mkv(6'h00, 6'h25, K_R,   1'b0, 1'b0, 2'b01, 2'b01, 5'd4, 4);
    tbl[5]  = mkv(6'h00, 6'h2a, K_R,   1'b0, 1'b0, 2'b01, 2'b01, 5'd5, 4);
    tbl[6]  = mkv(6'h00, 6'h08, K_JR,  1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 2);
    tbl[7]  = mkv(6'h08, 6'h00, K_I,   1'b1, 1'b1, 2'b00, 2'b01, 5'd0, 4);
    tbl[8]  = mkv(6'h09, 6'h00, K_I,   1'b1, 1'b1, 2'b00, 2'b01, 5'd1, 4);
    tbl[9]  = mkv(6'h0c, 6'h00, K_I,   1'b0, 1'b1, 2'b00, 2'b01, 5'd3, 4);
    tbl[10] = mkv(6'h0d, 6'h00, K_I,   1'b0, 1'b1, 2'b00, 2'b01, 5'd4, 4);
    tbl[11] = mkv(6'h0f, 6'h00, K_I,   1'b0, 1'b1, 2'b00, 2'b01, 5'd6, 4);
    tbl[12] = mkv(6'h23, 6'h00, K_LW,  1'b1, 1'b1, 2'b00, 2'b10, 5'd0, 5);
    tbl[13] = mkv(6'h2b, 6'h00, K_SW,  1'b1, 1'b1, 2'b00, 2'b00, 5'd0, 4);
    tbl[14] = mkv(6'h04, 6'h00, K_BEQ, 1'b1, 1'b0, 2'b00, 2'b00, 5'd2, 3);
    tbl[15] = mkv(6'h02, 6'h00, K_J,   1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 2);
    tbl[16] = mkv(6'h03, 6'h00, K_JAL, 1'b0, 1'b0, 2'b10, 2'b00, 5'd0, 3);
    tbl[17] = mkv(6'h3f, 6'h00, K_BAD, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0, BAD_CYC);
    tbl[18] = mkv(6'h00, 6'h3f, K_BAD, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0, BAD_CYC);

    rst = 1'b1; op = '0; funct = '0; mem_ready = 1'b0;
    #3;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", 32'({mem_read, mem_write, reg_write, pc_write, pc_write_cond,
                             ir_write, bus_err, illegal}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      op = tbl[i].op; funct = tbl[i].funct;
      build(tbl[i], 0, 0);
      run_queue(obs);
      check($sformatf("cycles_tbl%0d", i), 32'(obs), 32'(tbl[i].cycles));
    end

    // lw with three wait cycles in MEM
    op = tbl[12].op; funct = 6'h00;
    build(tbl[12], 0, 3);
    run_queue(obs);
    check("lw_wait_cycles", 32'(obs), 32'd8);

    // fetch completes in the last cycle before timeout
    op = tbl[1].op; funct = tbl[1].funct;
    build(tbl[1], MW - 1, 0);
    run_queue(obs);
    check("if_late_ready_cycles", 32'(obs), 32'(4 + MW - 1));

    // IF timeout into ERR, sticky
    for (int i = 0; i < MW; i++) begin
      e = mk(3'd0); e.rdy_any = 1'b0; e.rdy = 1'b0; e.mr = 1'b1; q.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      e = mk(3'd6); e.berr = 1'b1; q.push_back(e);
    end
    run_queue(obs);
    do_reset();
    check("err_cleared_by_rst", 32'({bus_err, state}), 32'd0);

    // MEM timeout into ERR
    op = tbl[12].op; funct = 6'h00;
    build(tbl[12], 0, 0);
    while (q.size() > 3) q.delete(q.size() - 1);
    for (int i = 0; i < MW; i++) begin
      e = cw(mk(3'd3), tbl[12]); e.rdy_any = 1'b0; e.rdy = 1'b0; e.iod = 1'b1; e.mr = 1'b1;
      q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      e = mk(3'd6); e.berr = 1'b1; q.push_back(e);
    end
    run_queue(obs);
    do_reset();

    // asynchronous reset in the middle of a sw access
    op = tbl[13].op; funct = 6'h00;
    build(tbl[13], 0, 3);
    while (q.size() > 4) q.delete(q.size() - 1);
    run_queue(obs);
    mem_ready = 1'b0;
    #2;
    check("sw_mem_write_held", 32'({mem_write, i_or_d, state}), 32'({1'b1, 1'b1, 3'd3}));
    rst = 1'b1;
    #1;
    check("rst_drops_mem_write", 32'({mem_write, mem_read}), 32'd0);
    check("rst_forces_if", 32'(state), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("if_after_release", 32'({mem_read, i_or_d, state}), 32'({1'b1, 1'b0, 3'd0}));
    do_reset();

    for (int n = 0; n < 150; n++) begin
      v = tbl[$urandom_range(0, 18)];
      op = v.op;
      funct = (v.op == 6'h00) ? v.funct : 6'($urandom_range(0, 63));
      wi = $urandom_range(0, MW - 1);
      wm = $urandom_range(0, MW - 1);
      build(v, wi, wm);
      run_queue(obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
